// File: rtl/seven_segment_reader.sv
// Reverse seven-segment decoder: glitch-filters a segment bus and reports each newly accepted pattern.
// Optional hex entries A-F enabled by defining SEVSEG_HEX_EN.
module seven_segment_reader #(
  parameter int STABLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seg_en,
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       blank,
  output logic       err
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic {ACQUIRE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [6:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    last_q, last_d;
  logic          last_ok_q, last_ok_d;
  logic [3:0]    digit_q, digit_d;
  logic          digit_valid_q, digit_valid_d;
  logic          blank_q, blank_d;
  logic          err_q, err_d;

  logic          accept;
  logic          pulse;
  logic [6:0]    acc_pat;
  logic [4:0]    dec;

  // Returns {known, value}
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = 5'h10;
      7'h06:   decode = 5'h11;
      7'h5B:   decode = 5'h12;
      7'h4F:   decode = 5'h13;
      7'h66:   decode = 5'h14;
      7'h6D:   decode = 5'h15;
      7'h7D:   decode = 5'h16;
      7'h07:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h6F:   decode = 5'h19;
`ifdef SEVSEG_HEX_EN
      7'h77:   decode = 5'h1A;
      7'h7C:   decode = 5'h1B;
      7'h39:   decode = 5'h1C;
      7'h5E:   decode = 5'h1D;
      7'h79:   decode = 5'h1E;
      7'h71:   decode = 5'h1F;
`endif
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    last_ok_d = last_ok_q;
    digit_d   = digit_q;
    accept    = 1'b0;
    acc_pat   = cand_q;

    if (seg_en) begin
      if (seg != cand_q) begin
        cand_d  = seg;
        cnt_d   = ONE_C;
        acc_pat = seg;
        if (STABLE == 1) begin
          state_d = HOLD;
          accept  = 1'b1;
        end else begin
          state_d = ACQUIRE;
        end
      end else if (state_q == ACQUIRE && cnt_q < STABLE_C) begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_d == STABLE_C) begin
          state_d = HOLD;
          accept  = 1'b1;
        end
      end
    end

    dec = decode(acc_pat);
    // A pattern returning after a short glitch matches last and stays silent
    pulse         = accept && (!last_ok_q || acc_pat != last_q);
    digit_valid_d = pulse;
    blank_d       = pulse && (acc_pat == 7'h00);
    err_d         = pulse && !dec[4] && (acc_pat != 7'h00);
    if (pulse) begin
      last_d    = acc_pat;
      last_ok_d = 1'b1;
      if (dec[4]) digit_d = dec[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACQUIRE;
      cand_q        <= '0;
      cnt_q         <= '0;
      last_q        <= '0;
      last_ok_q     <= 1'b0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      blank_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      last_ok_q     <= last_ok_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign blank       = blank_q;
  assign err         = err_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader (STABLE = 4); inputs driven and outputs sampled on the falling edge.
module tb_seven_segment_reader;

  logic       clk;
  logic       rst;
  logic       seg_en;
  logic [6:0] seg;
  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       err;

  int n_chk = 0;
  int n_err = 0;

  seven_segment_reader #(.STABLE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_en      (seg_en),
    .seg         (seg),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: apply inputs, let the edge pass, return at the next falling edge
  task automatic drive(input logic r, input logic en, input logic [6:0] s);
    rst    = r;
    seg_en = en;
    seg    = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold a pattern for 4 enabled cycles; expect a single pulse on the 4th when pulse_exp is set
  task automatic hold4(input string tag, input logic [6:0] s, input logic pulse_exp);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, s);
      chk(tag, digit_valid, (i == 3) ? pulse_exp : 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; seg_en = 1'b0; seg = 7'h00;
    @(negedge clk);
    drive(1'b1, 1'b0, 7'h00);
    drive(1'b1, 1'b1, 7'h3F);
    chk("rst_digit", digit, 4'h0);
    chk("rst_valid", digit_valid, 1'b0);
    chk("rst_blank", blank, 1'b0);
    chk("rst_err",   err, 1'b0);

    hold4("p2_valid", 7'h5B, 1'b1);
    chk("p2_digit", digit, 4'h2);
    chk("p2_err",   err, 1'b0);
    chk("p2_blank", blank, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 7'h5B);
      chk("p2_hold_nopulse", digit_valid, 1'b0);
    end

    hold4("p3_valid", 7'h4F, 1'b1);
    chk("p3_digit", digit, 4'h3);
    drive(1'b0, 1'b1, 7'h7F);
    chk("glitch_a", digit_valid, 1'b0);
    drive(1'b0, 1'b1, 7'h7F);
    chk("glitch_b", digit_valid, 1'b0);
    hold4("p3_return", 7'h4F, 1'b0);
    chk("p3_return_digit", digit, 4'h3);

    hold4("seq1_valid", 7'h06, 1'b1);
    chk("seq1_digit", digit, 4'h1);
    hold4("seq7_valid", 7'h07, 1'b1);
    chk("seq7_digit", digit, 4'h7);
    hold4("seq9_valid", 7'h6F, 1'b1);
    chk("seq9_digit", digit, 4'h9);

    hold4("blank_valid", 7'h00, 1'b1);
    chk("blank_flag", blank, 1'b1);
    chk("blank_err", err, 1'b0);
    chk("blank_digit", digit, 4'h9);
    drive(1'b0, 1'b1, 7'h00);
    chk("blank_clears", blank, 1'b0);

    hold4("bad_valid", 7'h01, 1'b1);
    chk("bad_err", err, 1'b1);
    chk("bad_blank", blank, 1'b0);
    chk("bad_digit", digit, 4'h9);
    drive(1'b0, 1'b1, 7'h01);
    chk("err_clears", err, 1'b0);

    hold4("hexA_valid", 7'h77, 1'b1);
`ifdef SEVSEG_HEX_EN
    chk("hexA_digit", digit, 4'hA);
    chk("hexA_err", err, 1'b0);
`else
    chk("hexA_digit", digit, 4'h9);
    chk("hexA_err", err, 1'b1);
`endif

    // seg_en toggling: 4th enabled sample lands on the 7th drive
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, (i % 2 == 0), 7'h6D);
      chk("en_toggle_valid", digit_valid, (i == 6));
    end
    chk("en_toggle_digit", digit, 4'h5);

    // Disabled cycles change nothing
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 7'h06);
      chk("disabled_nopulse", digit_valid, 1'b0);
    end
    chk("disabled_digit", digit, 4'h5);

    // Reset mid-run: sample in the reset cycle is ignored, run restarts
    drive(1'b0, 1'b1, 7'h7D);
    drive(1'b0, 1'b0, 7'h7D);
    drive(1'b1, 1'b1, 7'h6D);
    chk("midrst_digit", digit, 4'h0);
    chk("midrst_valid", digit_valid, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, (i % 2 == 0), 7'h6D);
      chk("post_rst_valid", digit_valid, (i == 6));
    end
    chk("post_rst_digit", digit, 4'h5);

    // First pattern after reset is 7'h3F: pulses with digit 0
    drive(1'b1, 1'b0, 7'h00);
    hold4("zero_valid", 7'h3F, 1'b1);
    chk("zero_digit", digit, 4'h0);
    chk("zero_err", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Reverse decoder for the seven-segment output interface. Samples a 7-bit segment bus, filters glitches with a stability counter and converts each accepted pattern back to its 4-bit digit value. Every newly accepted pattern produces a one-cycle report. Used in self-checking display benches and by loopback logic that monitors what a `seven_segment` driver is actually showing.

## Interface
- `STABLE`, default 4: consecutive identical enabled samples required to accept a pattern; legal range 1..255.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `seg_en` input 1: sample qualifier; `seg` is sampled only in cycles where it is 1.
- `seg` input 7: segment pattern `{g,f,e,d,c,b,a}`, active-high.
- `digit` output 4: last successfully decoded value.
- `digit_valid` output 1: one-cycle pulse marking an accepted new pattern.
- `blank` output 1: with `digit_valid`, the accepted pattern was 7'h00.
- `err` output 1: with `digit_valid`, the accepted pattern is not in the decode table.

## Operation
- Decode table (`seg` -> `digit`):
  - 0: 7'h3F; 1: 7'h06; 2: 7'h5B; 3: 7'h4F; 4: 7'h66.
  - 5: 7'h6D; 6: 7'h7D; 7: 7'h07; 8: 7'h7F; 9: 7'h6F.
  - Hex entries, only with the macro: A 7'h77, b 7'h7C, C 7'h39, d 7'h5E, E 7'h79, F 7'h71.
- Registers:
  - `cand` (7 bits): candidate pattern.
  - `cnt`: width `$clog2(STABLE+1)`, saturates at `STABLE`.
  - `last` (7 bits) plus `last_ok` flag: last accepted pattern.
- FSM states:
  - ACQUIRE: counting a run, `cnt < STABLE`.
  - HOLD: the current run reached `STABLE` and has been handled.
- Enabled sample with `seg == cand`:
  - `cnt` increments, saturating at `STABLE`.
  - When the increment reaches `STABLE`, the FSM goes ACQUIRE->HOLD and runs the accept check.
- Enabled sample with `seg != cand`:
  - `cand <= seg`, `cnt <= 1`, state goes to ACQUIRE.
  - With `STABLE == 1` this same sample triggers the accept check.
- Accept check:
  - If `!last_ok` or `cand != last`: set `last <= cand`, `last_ok <= 1`, pulse `digit_valid`.
  - Otherwise (the pattern returned after a glitch shorter than `STABLE`): no pulse.
- On a pulse:
  - Known pattern: `digit` updates to its value; `blank = 0`, `err = 0`.
  - 7'h00: `blank = 1`, `err = 0`, `digit` held.
  - Any other pattern: `err = 1`, `blank = 0`, `digit` held.
- Cycles with `seg_en == 0` change no state.
- In HOLD, further identical samples produce no pulses.

## Timing
- Reset values: `digit = 0`, `digit_valid = 0`, `blank = 0`, `err = 0`, `cand = 0`, `cnt = 0`, `last_ok = 0`, state ACQUIRE.
- `rst` is synchronous and takes priority over a sample in the same cycle.
- Latency:
  - The `STABLE`-th identical enabled sample, presented in cycle N, gives `digit`, `digit_valid`, `blank` and `err` registered and visible in cycle N+1.
  - Minimum latency from a pattern change is `STABLE` enabled cycles + 1.
- `blank` and `err` are meaningful only while `digit_valid = 1`; they are driven 0 otherwise.
- `digit` holds between pulses.
- The first pattern after reset always pulses, including 7'h3F (digit 0).
- Reset mid-run discards the run.
  - Example: a pattern that was accepted before reset pulses again once it is stable after reset.

## Configuration
- `SEVSEG_HEX_EN`:
  - Defined: the table includes A-F, so `digit` can reach 4'hA..4'hF.
  - Undefined: those six patterns report `err = 1` and `digit` is unchanged.
- No other behaviour differs between the two builds.

## Test plan
- Reset, then `seg = 7'h5B` with `seg_en = 1` for 4 cycles -> single `digit_valid` in cycle 5 with `digit = 2`, `err = 0`, `blank = 0`; no further pulses while held.
- Hold 7'h4F (accepted, 3), then a 2-cycle glitch 7'h7F, then 7'h4F again -> no second pulse; `digit` stays 3.
- Sequence 7'h06, 7'h07, 7'h6F, each held 4 cycles -> three pulses, `digit` = 1, 7, 9.
- Stable 7'h00 -> pulse with `blank = 1`, `digit` held; stable 7'h01 -> pulse with `err = 1`, `digit` held.
- Stable 7'h77:
  - With `SEVSEG_HEX_EN`: `digit = 4'hA`.
  - Without it: `err = 1`.
- `seg_en` toggled every other cycle with 7'h6D -> pulse after the 4th enabled sample (cycle 8), `digit = 5`; `rst` asserted in cycle 3 -> counting restarts and no early pulse occurs.
